// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) definitions: codeword geometry, bit position map
// and the encoder function used by both ham_enc_stream and ham_decoder.
package ham_pkg;

  localparam int HAM_N = 7;
  localparam int HAM_K = 4;

  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int D1_IDX = 2;
  localparam int P4_IDX = 3;
  localparam int D2_IDX = 4;
  localparam int D3_IDX = 5;
  localparam int D4_IDX = 6;

  function automatic logic [HAM_N-1:0] ham_encode(
    input logic [HAM_K-1:0] nib
  );
    logic [HAM_N-1:0] cw;
    cw         = '0;
    cw[D1_IDX] = nib[0];
    cw[D2_IDX] = nib[1];
    cw[D3_IDX] = nib[2];
    cw[D4_IDX] = nib[3];
    cw[P1_IDX] = nib[0] ^ nib[1] ^ nib[3];
    cw[P2_IDX] = nib[0] ^ nib[2] ^ nib[3];
    cw[P4_IDX] = nib[1] ^ nib[2] ^ nib[3];
    return cw;
  endfunction

endpackage

// File: rtl/ham_fifo2.sv
// Two-entry FIFO with pointer pair plus occupancy count.
// wr_ready depends only on registered state, never on rd_ready.
module ham_fifo2
  import ham_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data
);

  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       push;
  logic       pop;

  assign wr_ready = (cnt < 2'd2);
  assign rd_valid = (cnt != 2'd0);
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= 8'd0;
      mem[1] <= 8'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ham_enc_stream.sv
// Streaming Hamming(7,4) encoder with periodic single-bit error
// injection, buffered through a 2-entry output FIFO.
module ham_enc_stream
  import ham_pkg::*;
#(
  parameter int INJ_PERIOD = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [HAM_K-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [HAM_N-1:0] out_code,
  output logic             out_injected,
  input  logic             inj_en,
  input  logic [2:0]       inj_pos,
  output logic [CNT_W-1:0] word_cnt
);

  localparam logic [7:0] PH_LAST = 8'(INJ_PERIOD - 1);

  logic [7:0]       phase;
  logic             accept;
  logic             hit;
  logic [HAM_N-1:0] mask;
  logic [HAM_N-1:0] code;
  logic [7:0]       rd_word;

  assign accept = in_valid & in_ready;
  assign hit    = (phase == PH_LAST) & inj_en & (inj_pos != 3'd0);

  // One-hot flip mask; inj_pos=0 yields no bit
  always_comb begin
    mask = '0;
    for (int i = 0; i < HAM_N; i++) begin
      mask[i] = (inj_pos == 3'(i + 1));
    end
  end

  assign code = ham_encode(in_data) ^ (hit ? mask : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= 8'd0;
      word_cnt <= '0;
    end else if (accept) begin
      phase    <= (phase == PH_LAST) ? 8'd0 : phase + 8'd1;
      word_cnt <= word_cnt + 1'b1;
    end
  end

  ham_fifo2 u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  ({hit, code}),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (rd_word)
  );

  assign out_code     = rd_word[HAM_N-1:0];
  assign out_injected = rd_word[7];

endmodule

// File: tb/tb_ham_enc_stream.sv
// Directed bench for ham_enc_stream: reset, encoding, injection,
// backpressure, simultaneous push/pop and mid-stream reset.
module tb_ham_enc_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_code;
  logic        out_injected;
  logic        inj_en;
  logic [2:0]  inj_pos;
  logic [15:0] word_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ham_enc_stream dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_code     (out_code),
    .out_injected (out_injected),
    .inj_en       (inj_en),
    .inj_pos      (inj_pos),
    .word_cnt     (word_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b1;
    inj_en = 1'b0; inj_pos = 3'd0;
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_code !== 7'd0 || out_injected !== 1'b0) begin
      errors++;
      $display("FAIL rst_out got %b/%b want 0000000/0", out_code, out_injected);
    end
    checks++;
    if (word_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_word_cnt got %0d want 0", word_cnt);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 4'b1011;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_code !== 7'b1010101) begin
      errors++;
      $display("FAIL single_code got %b/%b want 1/1010101", out_valid, out_code);
    end
    checks++;
    if (out_injected !== 1'b0) begin
      errors++; $display("FAIL single_inj got %b want 0", out_injected);
    end
    checks++;
    if (word_cnt !== 16'd1) begin
      errors++; $display("FAIL single_cnt got %0d want 1", word_cnt);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_data = 4'h0;
    tick();
    in_data = 4'hF;
    checks++;
    if (out_code !== 7'b0000000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got %b rdy %b want 0000000 rdy 1", out_code, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_code !== 7'b1111111 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got %b/%b want 1/1111111", out_valid, out_code);
    end
    tick();
  endtask

  task automatic test_inject();
    logic [6:0] exp;
    do_reset();
    inj_en = 1'b1; inj_pos = 3'd5; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 4'b1011;
      tick();
      exp = (i == 3) ? 7'b1000101 : 7'b1010101;
      checks++;
      if (out_code !== exp || out_injected !== (i == 3)) begin
        errors++;
        $display("FAIL inject_w%0d got %b/%b want %b/%b",
                 i, out_code, out_injected, exp, (i == 3));
      end
    end
    in_valid = 1'b0; inj_en = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h3;
    tick();
    in_data = 4'h5;
    tick();
    in_data = 4'h9;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_code !== 7'b0011110) begin
      errors++;
      $display("FAIL bp_hold got rdy %b %b want rdy 0 0011110", in_ready, out_code);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_code !== 7'b0101101 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain2 got %b rdy %b want 0101101 rdy 1", out_code, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_code !== 7'b1001100 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain3 got %b/%b want 1/1001100", out_valid, out_code);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || word_cnt !== 16'd7) begin
      errors++;
      $display("FAIL bp_end got v %b cnt %0d want v 0 cnt 7", out_valid, word_cnt);
    end
  endtask

  task automatic test_push_pop();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'hF;
    tick();
    out_ready = 1'b1; in_data = 4'h0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_code !== 7'b0000000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pushpop got v %b %b rdy %b want v 1 0000000 rdy 1",
               out_valid, out_code, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL pushpop_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_full();
    logic [6:0] exp;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h3;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL rstfull_pre got %b want 0", in_ready);
    end
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || word_cnt !== 16'd0 ||
        out_code !== 7'd0) begin
      errors++;
      $display("FAIL rstfull_post got v %b rdy %b cnt %0d code %b",
               out_valid, in_ready, word_cnt, out_code);
    end
    inj_en = 1'b1; inj_pos = 3'd1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 4'h0;
      tick();
      exp = (i == 3) ? 7'b0000001 : 7'b0000000;
      checks++;
      if (out_code !== exp || out_injected !== (i == 3)) begin
        errors++;
        $display("FAIL rstfull_inj_w%0d got %b/%b want %b/%b",
                 i, out_code, out_injected, exp, (i == 3));
      end
    end
    in_valid = 1'b0; inj_en = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_inject();
    test_backpressure();
    test_push_pop();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
